// File: rtl/ht_res_collector_pkg.sv
// Hash-table result-side types: result codes, commands, the queued result word
// and the statistics counter indices used by ht_res_collector.
package ht_res_collector_pkg;

    localparam int unsigned KEY_WIDTH   = 32;
    localparam int unsigned VALUE_WIDTH = 16;
    localparam int unsigned CNT_NUM     = 8;

    typedef enum logic [1:0] {
        CMD_SEARCH = 2'd0,
        CMD_INSERT = 2'd1,
        CMD_DELETE = 2'd2,
        CMD_NONE   = 2'd3
    } ht_cmd_t;

    typedef enum logic [2:0] {
        SEARCH_FOUND                     = 3'd0,
        SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
        INSERT_SUCCESS                   = 3'd2,
        DELETE_SUCCESS                   = 3'd3,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
        DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd5,
        INSERT_SUCCESS_SAME_KEY          = 3'd6,
        RESCODE_UNDEF                    = 3'd7
    } ht_rescode_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        ht_cmd_t                cmd;
        ht_rescode_t            rescode;
    } ht_res_word_t;

    typedef enum logic [2:0] {
        CNT_SEARCH_FOUND          = 3'd0,
        CNT_SEARCH_NO_ENTRY       = 3'd1,
        CNT_INSERT_SUCCESS        = 3'd2,
        CNT_INSERT_SAME_KEY       = 3'd3,
        CNT_INSERT_TABLE_FULL     = 3'd4,
        CNT_DELETE_SUCCESS        = 3'd5,
        CNT_DELETE_NO_ENTRY       = 3'd6,
        CNT_OTHER                 = 3'd7
    } ht_cnt_idx_t;

    // Map a result code to the counter it bumps; anything unrecognised is CNT_OTHER.
    function automatic ht_cnt_idx_t rescode_to_cnt_idx(input ht_rescode_t rc);
        case (rc)
            SEARCH_FOUND:                     return CNT_SEARCH_FOUND;
            SEARCH_NOT_SUCCESS_NO_ENTRY:      return CNT_SEARCH_NO_ENTRY;
            INSERT_SUCCESS:                   return CNT_INSERT_SUCCESS;
            INSERT_SUCCESS_SAME_KEY:          return CNT_INSERT_SAME_KEY;
            INSERT_NOT_SUCCESS_TABLE_IS_FULL: return CNT_INSERT_TABLE_FULL;
            DELETE_SUCCESS:                   return CNT_DELETE_SUCCESS;
            DELETE_NOT_SUCCESS_NO_ENTRY:      return CNT_DELETE_NO_ENTRY;
            default:                          return CNT_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/ht_res_if.sv
// Result stream leaving hash_table_top: one result per valid/ready handshake.
interface ht_res_if;
    import ht_res_collector_pkg::*;

    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    ht_cmd_t                cmd;
    ht_rescode_t            rescode;
    logic                   valid;
    logic                   ready;

    modport source (output key, value, cmd, rescode, valid, input ready);
    modport sink   (input key, value, cmd, rescode, valid, output ready);

endinterface

// File: rtl/ht_res_fifo.sv
// Show-ahead FIFO of result words; head entry is presented without a read request.
module ht_res_fifo
    import ht_res_collector_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  ht_res_word_t          wr_data,
    input  logic                  rd_en,
    output ht_res_word_t          rd_data,
    output logic [DEPTH_LOG2:0]   used,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] USED_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    ht_res_word_t            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     used_q;
    logic                    wr_fire;
    logic                    rd_fire;

    assign full    = (used_q == USED_FULL);
    assign empty   = (used_q == '0);
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign used    = used_q;

    // Storage is not reset; the head is forced to zero while the FIFO is empty.
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   used_q <= used_q + (DEPTH_LOG2 + 1)'(1);
                2'b01:   used_q <= used_q - (DEPTH_LOG2 + 1)'(1);
                default: used_q <= used_q;
            endcase
        end
    end

endmodule

// File: rtl/ht_res_collector.sv
// Terminates the hash-table result stream: queues results for a host reader
// and keeps saturating per-outcome event counters.
module ht_res_collector
    import ht_res_collector_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    ht_res_if.sink                               ht_res_in,
    input  logic                                 pop_i,
    output logic                                 rd_valid_o,
    output logic [KEY_WIDTH-1:0]                 rd_key_o,
    output logic [VALUE_WIDTH-1:0]               rd_value_o,
    output ht_cmd_t                              rd_cmd_o,
    output ht_rescode_t                          rd_rescode_o,
    output logic [FIFO_DEPTH_LOG2:0]             fifo_used_o,
    input  logic                                 cnt_clr_i,
    output logic [CNT_NUM-1:0][CNT_WIDTH-1:0]    cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    ht_res_word_t                      wr_word;
    ht_res_word_t                      rd_word;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic                              accept;
    logic                              pop;
    ht_cnt_idx_t                       acc_idx;
    logic [CNT_NUM-1:0][CNT_WIDTH-1:0] cnt_q;

    // ready depends only on the registered occupancy, never on pop_i.
    assign ht_res_in.ready = !fifo_full;
    assign accept          = ht_res_in.valid && !fifo_full;
    assign pop             = pop_i && !fifo_empty;

    assign wr_word.key     = ht_res_in.key;
    assign wr_word.value   = ht_res_in.value;
    assign wr_word.cmd     = ht_res_in.cmd;
    assign wr_word.rescode = ht_res_in.rescode;

    ht_res_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (accept),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_data (rd_word),
        .used    (fifo_used_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_valid_o   = !fifo_empty;
    assign rd_key_o     = rd_word.key;
    assign rd_value_o   = rd_word.value;
    assign rd_cmd_o     = rd_word.cmd;
    assign rd_rescode_o = rd_word.rescode;

    assign acc_idx = rescode_to_cnt_idx(ht_res_in.rescode);

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q[acc_idx] != CNT_MAX)) begin
            cnt_q[acc_idx] <= cnt_q[acc_idx] + CNT_WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule
